// File: rtl/life_scheduler_if.sv
// life_scheduler_if
//   Bundles every non-clock, non-reset signal of the Game-of-Life
//   scheduler: user requests, the datapath cell port and the VGA plot port.
//   master: the environment side (requester + datapath), drives requests and
//           cell_alive, observes the scheduler outputs.
//   slave : the scheduler itself.
interface life_scheduler_if #(
    parameter int COLS_LOG2 = 3,
    parameter int ROWS_LOG2 = 3
);
    // requests
    logic                 run;
    logic                 step;
    logic                 edit_req;
    logic [COLS_LOG2-1:0] edit_x;
    logic [ROWS_LOG2-1:0] edit_y;
    // datapath port
    logic                 cell_alive;
    logic [COLS_LOG2-1:0] cell_x;
    logic [ROWS_LOG2-1:0] cell_y;
    logic                 calc_en;
    logic                 commit_en;
    logic                 toggle_en;
    // VGA plot port
    logic                 plot;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           colour;
    // status
    logic                 ready;
    logic                 gen_done;
    logic [15:0]          gen_count;

    modport master (
        output run, step, edit_req, edit_x, edit_y, cell_alive,
        input  cell_x, cell_y, calc_en, commit_en, toggle_en,
        input  plot, vga_x, vga_y, colour, ready, gen_done, gen_count
    );

    modport slave (
        input  run, step, edit_req, edit_x, edit_y, cell_alive,
        output cell_x, cell_y, calc_en, commit_en, toggle_en,
        output plot, vga_x, vga_y, colour, ready, gen_done, gen_count
    );
endinterface

// File: rtl/life_scheduler.sv
// life_scheduler
//   Sequences the Game-of-Life datapath and a 160x120 VGA adapter. Each
//   generation sweeps the grid three times: calculate, commit, redraw.
//   User cell edits toggle one cell and redraw only that cell. A free-running
//   tick timer requests generations while run is high.
// Ports
//   clk    : system clock
//   resetn : synchronous, active-low reset
//   bus    : life_scheduler_if.slave (requests, datapath port, plot port,
//            ready / gen_done / gen_count status)
// All outputs are decoded from registered state and counters only, except
// colour, which follows the datapath's combinational cell_alive.
module life_scheduler #(
    parameter int          COLS_LOG2    = 3,
    parameter int          ROWS_LOG2    = 3,
    parameter int          PX_LOG2      = 2,
    parameter int          TICK_CYCLES  = 5_000_000,
    parameter logic [2:0]  COLOUR_ALIVE = 3'b100
) (
    input  logic              clk,
    input  logic              resetn,
    life_scheduler_if.slave   bus
);
    localparam int CELL_W = COLS_LOG2 + ROWS_LOG2;
    localparam int PIX_W  = 2 * PX_LOG2;
    localparam int TICK_W = $clog2(TICK_CYCLES);

    typedef enum logic [2:0] {
        INIT_DRAW, IDLE, EDIT, EDIT_DRAW, CALC, COMMIT, GEN_DRAW
    } state_t;

    state_t               state_q, state_d;
    logic [CELL_W-1:0]    cell_q, cell_d;        // raster cell index, x in low bits
    logic [PIX_W-1:0]     pix_q, pix_d;          // pixel within cell, px in low bits
    logic [COLS_LOG2-1:0] edit_x_q, edit_x_d;
    logic [ROWS_LOG2-1:0] edit_y_q, edit_y_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic                 tick_pending_q, tick_pending_d;
    logic [15:0]          gen_count_q, gen_count_d;

    logic cell_last, pix_last, tick_wrap, gen_start;

    assign cell_last = &cell_q;
    assign pix_last  = &pix_q;
    assign tick_wrap = (tick_q == TICK_W'(TICK_CYCLES - 1));

    // Every sweep ends with its counter wrapping to zero, so IDLE always
    // starts with cell_q = pix_q = 0 and no explicit clear is needed.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d        = state_q;
        cell_d         = cell_q;
        pix_d          = pix_q;
        edit_x_d       = edit_x_q;
        edit_y_d       = edit_y_q;
        gen_count_d    = gen_count_q;
        gen_start      = 1'b0;

        case (state_q)
            INIT_DRAW, GEN_DRAW: begin
                pix_d = pix_q + 1'b1;
                if (pix_last) begin
                    cell_d = cell_q + 1'b1;
                    if (cell_last) state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.edit_req) begin
                    edit_x_d = bus.edit_x;
                    edit_y_d = bus.edit_y;
                    state_d  = EDIT;
                end else if (bus.step || (bus.run && tick_pending_q)) begin
                    gen_start = 1'b1;
                    state_d   = CALC;
                end
            end
            EDIT: state_d = EDIT_DRAW;
            EDIT_DRAW: begin
                pix_d = pix_q + 1'b1;
                if (pix_last) state_d = IDLE;
            end
            CALC: begin
                cell_d = cell_q + 1'b1;
                if (cell_last) state_d = COMMIT;
            end
            COMMIT: begin
                cell_d = cell_q + 1'b1;
                if (cell_last) begin
                    gen_count_d = gen_count_q + 16'd1;
                    state_d     = GEN_DRAW;
                end
            end
            default: state_d = INIT_DRAW;
        endcase

        // Tick timer. Any generation launched from IDLE consumes a pending
        // tick, so a step that coincides with a tick yields one generation.
        tick_d         = '0;
        tick_pending_d = 1'b0;
        if (bus.run) begin
            tick_d         = tick_wrap ? '0 : tick_q + 1'b1;
            tick_pending_d = tick_pending_q | tick_wrap;
            if (gen_start) tick_pending_d = 1'b0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // flop samples the values computed for this cycle, not partial updates.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= INIT_DRAW;
            cell_q         <= '0;
            pix_q          <= '0;
            edit_x_q       <= '0;
            edit_y_q       <= '0;
            tick_q         <= '0;
            tick_pending_q <= 1'b0;
            gen_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cell_q         <= cell_d;
            pix_q          <= pix_d;
            edit_x_q       <= edit_x_d;
            edit_y_q       <= edit_y_d;
            tick_q         <= tick_d;
            tick_pending_q <= tick_pending_d;
            gen_count_q    <= gen_count_d;
        end
    end

    // Moore output decode
    logic edit_phase;
    assign edit_phase = (state_q == EDIT) || (state_q == EDIT_DRAW);

    assign bus.cell_x    = (state_q == IDLE) ? '0
                         : edit_phase ? edit_x_q : cell_q[COLS_LOG2-1:0];
    assign bus.cell_y    = (state_q == IDLE) ? '0
                         : edit_phase ? edit_y_q : cell_q[CELL_W-1:COLS_LOG2];
    assign bus.calc_en   = (state_q == CALC);
    assign bus.commit_en = (state_q == COMMIT);
    assign bus.toggle_en = (state_q == EDIT);
    assign bus.plot      = (state_q == INIT_DRAW) || (state_q == EDIT_DRAW)
                         || (state_q == GEN_DRAW);
    // Pixel address is the cell address with the in-cell offset appended.
    assign bus.vga_x     = 8'({bus.cell_x, pix_q[PX_LOG2-1:0]});
    assign bus.vga_y     = 7'({bus.cell_y, pix_q[PIX_W-1:PX_LOG2]});
    assign bus.colour    = bus.cell_alive ? COLOUR_ALIVE : 3'b000;
    assign bus.ready     = (state_q == IDLE);
    assign bus.gen_done  = (state_q == GEN_DRAW) && cell_last && pix_last;
    assign bus.gen_count = gen_count_q;
endmodule

// File: tb/tb_life_scheduler.sv
// tb_life_scheduler
//   Drives life_scheduler with directed and randomized requests, plays the
//   role of the cell datapath and the VGA frame buffer, and compares the
//   outcome against a whole-grid Game-of-Life reference model.
module tb_life_scheduler;
    localparam int TICK = 2000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    life_scheduler_if #(.COLS_LOG2(3), .ROWS_LOG2(3)) bus ();

    life_scheduler #(
        .COLS_LOG2(3), .ROWS_LOG2(3), .PX_LOG2(2),
        .TICK_CYCLES(TICK), .COLOUR_ALIVE(3'b100)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------
    // Datapath + frame buffer played by the bench (acts at negedge)
    // ------------------------------------------------------------------
    bit [63:0]  cur = '0;            // datapath current grid
    bit [63:0]  tmp = '0;            // datapath temp grid
    bit [63:0]  exp_grid = '0;       // reference model grid
    logic [2:0] fb [0:31][0:31];
    wire  [5:0] cur_idx = {bus.cell_y, bus.cell_x};

    assign bus.cell_alive = cur[cur_idx];

    function automatic bit life_next(input bit [63:0] g, input int idx);
        int x = idx % 8;
        int y = idx / 8;
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 &&
                    y + dy >= 0 && y + dy < 8)
                    n += int'(g[(y + dy) * 8 + x + dx]);
        return g[idx] ? (n == 2 || n == 3) : (n == 3);
    endfunction

    function automatic bit [63:0] life_step(input bit [63:0] g);
        bit [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = life_next(g, i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.plot)      fb[bus.vga_y[4:0]][bus.vga_x[4:0]] <= bus.colour;
        if (bus.calc_en)   tmp[cur_idx] <= life_next(cur, int'(cur_idx));
        if (bus.commit_en) cur[cur_idx] <= tmp[cur_idx];
        if (bus.toggle_en) cur[cur_idx] <= ~cur[cur_idx];
    end

    // Number of cells whose 16 pixels do not all show the model's colour.
    function automatic int fb_bad();
        int n = 0;
        for (int c = 0; c < 64; c++) begin
            bit ok = 1'b1;
            for (int p = 0; p < 16; p++)
                if (fb[(c / 8) * 4 + p / 4][(c % 8) * 4 + p % 4] !==
                    (exp_grid[c] ? 3'b100 : 3'b000)) ok = 1'b0;
            if (!ok) n++;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        int busy, n_plot, n_calc, n_commit, n_toggle, n_done;
        int done_cycle, tog_idx, tog_cycle, calc_bad, commit_bad;
        int min_x, max_x, min_y, max_y, first_x, first_y, last_x, last_y;
        int gc_last_commit, gc_first_draw;
    } stats_t;

    // Samples every busy cycle until ready returns (or the budget expires,
    // which shows up as a wrong busy count). If poke_at >= 0, step and
    // edit_req are held high for five busy cycles starting there.
    task automatic observe(input int budget, input int poke_at,
                           output stats_t s);
        s = '{default: 0};
        s.min_x = 999; s.min_y = 999; s.max_x = -1; s.max_y = -1;
        s.tog_idx = -1; s.tog_cycle = -1; s.done_cycle = -1;
        s.gc_last_commit = -1; s.gc_first_draw = -1;
        while (!bus.ready && s.busy < budget) begin
            int idx;
            idx = int'(cur_idx);
            if (poke_at >= 0) begin
                bus.step     = (s.busy >= poke_at && s.busy < poke_at + 5);
                bus.edit_req = bus.step;
            end
            if (bus.calc_en) begin
                if (idx != s.n_calc % 64) s.calc_bad++;
                s.n_calc++;
            end
            if (bus.commit_en) begin
                if (idx != s.n_commit % 64) s.commit_bad++;
                s.n_commit++;
                if (s.n_commit == 64) s.gc_last_commit = int'(bus.gen_count);
            end
            if (bus.toggle_en) begin
                s.n_toggle++;
                s.tog_idx   = idx;
                s.tog_cycle = s.busy;
            end
            if (bus.plot) begin
                if (s.n_plot == 0) begin
                    s.first_x = int'(bus.vga_x);
                    s.first_y = int'(bus.vga_y);
                end
                s.last_x = int'(bus.vga_x);
                s.last_y = int'(bus.vga_y);
                if (int'(bus.vga_x) < s.min_x) s.min_x = int'(bus.vga_x);
                if (int'(bus.vga_x) > s.max_x) s.max_x = int'(bus.vga_x);
                if (int'(bus.vga_y) < s.min_y) s.min_y = int'(bus.vga_y);
                if (int'(bus.vga_y) > s.max_y) s.max_y = int'(bus.vga_y);
                if (s.gc_first_draw < 0 && s.n_commit > 0)
                    s.gc_first_draw = int'(bus.gen_count);
                s.n_plot++;
            end
            if (bus.gen_done) begin
                s.n_done++;
                s.done_cycle = s.busy;
            end
            s.busy++;
            tick();
        end
        if (poke_at >= 0) begin
            bus.step     = 1'b0;
            bus.edit_req = 1'b0;
        end
    endtask

    // Full-grid redraw after reset: 1024 plots, raster cell order.
    task automatic check_init_draw(input string tag);
        stats_t s;
        observe(3000, -1, s);
        check({tag, "_busy"},    s.busy, 1024);
        check({tag, "_plots"},   s.n_plot, 1024);
        check({tag, "_first_x"}, s.first_x, 0);
        check({tag, "_first_y"}, s.first_y, 0);
        check({tag, "_last_x"},  s.last_x, 31);
        check({tag, "_last_y"},  s.last_y, 31);
        check({tag, "_enables"}, s.n_calc + s.n_commit + s.n_toggle, 0);
        check({tag, "_fb"},      fb_bad(), 0);
        check({tag, "_ready"},   bus.ready, 1);
    endtask

    task automatic do_edit(input int x, input int y, input string tag);
        stats_t s;
        bus.edit_x   = 3'(x);
        bus.edit_y   = 3'(y);
        bus.edit_req = 1'b1;
        tick();
        bus.edit_req = 1'b0;
        observe(100, -1, s);
        exp_grid[y * 8 + x] = ~exp_grid[y * 8 + x];
        check({tag, "_busy"},     s.busy, 17);
        check({tag, "_toggles"},  s.n_toggle, 1);
        check({tag, "_tog_idx"},  s.tog_idx, y * 8 + x);
        check({tag, "_tog_cyc"},  s.tog_cycle, 0);
        check({tag, "_plots"},    s.n_plot, 16);
        check({tag, "_xrange"},   {s.min_x[15:0], s.max_x[15:0]},
                                  {16'(x * 4), 16'(x * 4 + 3)});
        check({tag, "_yrange"},   {s.min_y[15:0], s.max_y[15:0]},
                                  {16'(y * 4), 16'(y * 4 + 3)});
    endtask

    // One generation (step-initiated), optionally poking requests mid-CALC.
    task automatic do_step(input int poke_at, input int gc_before,
                           input string tag);
        stats_t s;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        observe(2000, poke_at, s);
        exp_grid = life_step(exp_grid);
        check({tag, "_busy"},       s.busy, 1152);
        check({tag, "_calc"},       s.n_calc, 64);
        check({tag, "_calc_order"}, s.calc_bad, 0);
        check({tag, "_commit"},     s.n_commit, 64);
        check({tag, "_commit_ord"}, s.commit_bad, 0);
        check({tag, "_toggles"},    s.n_toggle, 0);
        check({tag, "_plots"},      s.n_plot, 1024);
        check({tag, "_gc_commit"},  s.gc_last_commit, gc_before);
        check({tag, "_gc_draw"},    s.gc_first_draw, gc_before + 1);
        check({tag, "_done_cnt"},   s.n_done, 1);
        check({tag, "_done_last"},  s.done_cycle, s.busy - 1);
        check({tag, "_fb"},         fb_bad(), 0);
        check({tag, "_grid"},       cur, exp_grid);
    endtask

    // ------------------------------------------------------------------
    // Directed + randomized sequence
    // ------------------------------------------------------------------
    initial begin
        int gc_model;
        int starts;
        int start_cyc [4];
        int dones;
        int gc_at_4th;
        int idle_ok;
        bit found;
        stats_t s;

        resetn       = 1'b0;
        bus.run      = 1'b0;
        bus.step     = 1'b0;
        bus.edit_req = 1'b0;
        bus.edit_x   = '0;
        bus.edit_y   = '0;
        gc_model     = 0;

        // Reset state
        tick();
        tick();
        check("rst_ready",    bus.ready, 0);
        check("rst_gen_cnt",  bus.gen_count, 0);
        check("rst_gen_done", bus.gen_done, 0);
        check("rst_enables",  {bus.calc_en, bus.commit_en, bus.toggle_en}, 0);
        check("rst_plot",     bus.plot, 1);
        check("rst_vga",      {bus.vga_x, bus.vga_y}, 0);
        resetn = 1'b1;
        check_init_draw("init");

        // Directed edit at (2,5)
        do_edit(2, 5, "edit25");
        check("edit25_fb",   fb_bad(), 0);
        check("edit25_grid", cur, exp_grid);

        // Randomized edits clustered so that generations have live cells
        for (int i = 0; i < 10; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            do_edit(2 + int'($urandom_range(0, 3)), 2 + int'($urandom_range(0, 3)),
                    $sformatf("redit%0d", i));
        end
        check("redit_fb",   fb_bad(), 0);
        check("redit_grid", cur, exp_grid);

        // Single step
        do_step(-1, gc_model, "step1");
        gc_model++;
        check("step1_gen_count", bus.gen_count, 16'(gc_model));

        // Step with step/edit_req held during CALC: both must be ignored
        do_step(10, gc_model, "step2");
        gc_model++;
        tick();
        tick();
        check("step2_no_retrigger", bus.ready, 1);
        check("step2_gen_count",    bus.gen_count, 16'(gc_model));

        // Simultaneous edit_req and step in IDLE: only the edit happens
        bus.edit_x   = 3'd4;
        bus.edit_y   = 3'd1;
        bus.edit_req = 1'b1;
        bus.step     = 1'b1;
        tick();
        bus.edit_req = 1'b0;
        bus.step     = 1'b0;
        observe(2000, -1, s);
        exp_grid[1 * 8 + 4] = ~exp_grid[1 * 8 + 4];
        check("both_busy",   s.busy, 17);
        check("both_toggle", s.n_toggle, 1);
        check("both_calc",   s.n_calc, 0);
        tick();
        check("both_idle",   bus.ready, 1);
        check("both_grid",   cur, exp_grid);

        // Run mode: generations at successive ticks, drop run during the 4th
        starts = 0;
        dones  = 0;
        gc_at_4th = -1;
        idle_ok = 1;
        bus.run = 1'b1;
        for (int c = 0; c < 12000; c++) begin
            if (bus.calc_en && cur_idx == 6'd0) begin
                if (starts < 4) start_cyc[starts] = c;
                if (starts == 3) gc_at_4th = int'(bus.gen_count);
                starts++;
                if (!bus.run) idle_ok = 0;
            end
            if (bus.gen_done) begin
                dones++;
                exp_grid = life_step(exp_grid);
            end
            if (starts == 4 && bus.run && c == start_cyc[3] + 10) bus.run = 1'b0;
            tick();
        end
        bus.run = 1'b0;
        check("run_starts",    starts, 4);
        check("run_first_dly", (start_cyc[0] >= TICK && start_cyc[0] <= TICK + 2), 1);
        check("run_period1",   start_cyc[1] - start_cyc[0], TICK);
        check("run_period2",   start_cyc[2] - start_cyc[1], TICK);
        check("run_period3",   start_cyc[3] - start_cyc[2], TICK);
        check("run_gc_at_3",   gc_at_4th, gc_model + 3);
        check("run_stopped",   idle_ok, 1);
        check("run_done_cnt",  dones, 4);
        gc_model += 4;
        check("run_gen_count", bus.gen_count, 16'(gc_model));
        check("run_ready",     bus.ready, 1);
        check("run_fb",        fb_bad(), 0);
        check("run_grid",      cur, exp_grid);

        // Reset in the middle of CALC (index 30)
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (bus.calc_en && cur_idx == 6'd30) found = 1'b1;
            else tick();
        end
        check("mid_found_idx30", found, 1);
        resetn = 1'b0;
        tick();
        check("mid_calc_en",   bus.calc_en, 0);
        check("mid_commit_en", bus.commit_en, 0);
        check("mid_plot",      bus.plot, 1);
        check("mid_vga",       {bus.vga_x, bus.vga_y}, 0);
        check("mid_gen_count", bus.gen_count, 0);
        tick();
        resetn = 1'b1;
        gc_model = 0;
        check_init_draw("reinit");
        check("reinit_grid",      cur, exp_grid);
        check("reinit_gen_count", bus.gen_count, 16'(gc_model));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/life_scheduler.md
# life_scheduler

Sequencer for the Game-of-Life cell datapath and the 160x120 VGA adapter. It arbitrates between user cell edits, single-step requests and a free-running generation timer. For each generation it sweeps the grid three times, in order: calculate next state, commit, redraw. It also turns cell coordinates into CELL_PX x CELL_PX pixel blocks for the VGA plot port.

## Interface
- COLS_LOG2, default 3: log2 of grid columns (8).
- ROWS_LOG2, default 3: log2 of grid rows (8).
- PX_LOG2, default 2: log2 of the cell edge in pixels (CELL_PX = 4).
- TICK_CYCLES, default 5_000_000: clk cycles between generations in run mode. Must be at least 2.
- COLOUR_ALIVE, default 3'b100: plot colour for a live cell. Dead cells plot 3'b000.
- clk, in, 1: system clock.
- resetn, in, 1: reset, synchronous, active-low.
- run, in, 1: level. Enables timed generations.
- step, in, 1: request for one generation. Accepted only when ready=1.
- edit_req, in, 1: request to toggle one cell. Accepted only when ready=1.
- edit_x, in, COLS_LOG2: column of the cell to toggle. Sampled on acceptance.
- edit_y, in, ROWS_LOG2: row of the cell to toggle. Sampled on acceptance.
- cell_alive, in, 1: datapath's current state of the cell at (cell_x, cell_y). Combinational, same cycle.
- cell_x, out, COLS_LOG2: cell address to the datapath.
- cell_y, out, ROWS_LOG2: cell address to the datapath.
- calc_en, out, 1: datapath writes the next state of the addressed cell into its temp grid.
- commit_en, out, 1: datapath copies the temp grid into the current grid for the addressed cell.
- toggle_en, out, 1: datapath inverts the addressed cell.
- plot, out, 1: VGA write enable.
- vga_x, out, 8: pixel x coordinate.
- vga_y, out, 7: pixel y coordinate.
- colour, out, 3: pixel colour.
- ready, out, 1: high in IDLE only.
- gen_done, out, 1: one-cycle pulse when a generation's redraw finishes.
- gen_count, out, 16: number of committed generations. Wraps from 0xFFFF to 0.

## Operation
- States: INIT_DRAW, IDLE, EDIT, EDIT_DRAW, CALC, COMMIT, GEN_DRAW.
- All outputs are Moore-decoded from the state and the counters. They are valid in the cycle they are asserted, and the datapath and VGA sample them on the next clk edge.
- Cell sweep: index 0 to N-1 with N = 2^(COLS_LOG2+ROWS_LOG2). Raster order, x fastest. cell_x is the low bits of the index and cell_y the high bits.
- Pixel sweep within a cell: CELL_PX^2 cycles, px fastest then py.
  - vga_x = cell_x*CELL_PX + px.
  - vga_y = cell_y*CELL_PX + py.
  - colour = cell_alive ? COLOUR_ALIVE : 0.
- INIT_DRAW: full-grid pixel sweep with plot=1 (N*CELL_PX^2 cycles), then IDLE.
- IDLE: cell_x = cell_y = 0 and all enables low. Accepted events, in priority order:
  1. edit_req: latch edit_x and edit_y, go to EDIT.
  2. step: go to CALC.
  3. run & tick_pending: go to CALC and clear tick_pending.
- EDIT: toggle_en=1 for one cycle at the latched cell, then EDIT_DRAW.
- EDIT_DRAW: pixel sweep of the latched cell only (CELL_PX^2 cycles), then IDLE.
- CALC: calc_en=1 for N cycles, one per cell, then COMMIT.
- COMMIT: commit_en=1 for N cycles. gen_count increments on the last COMMIT cycle, then GEN_DRAW.
- GEN_DRAW: full-grid pixel sweep. gen_done=1 in its last cycle, then IDLE.
- Tick timer:
  - Counts only while run=1 and resets to 0 when run=0.
  - When it reaches TICK_CYCLES-1 it wraps to 0 and sets tick_pending.
  - tick_pending is not cumulative: further ticks while it is already set are dropped.
  - tick_pending is cleared when run=0 or when a timed generation starts.
- Requests while ready=0 are ignored. Requests are not queued; the requester must re-assert.

## Timing
- Reset values:
  - state = INIT_DRAW, all counters 0, tick_pending 0.
  - gen_count 0, gen_done 0, ready 0.
  - calc_en, commit_en, toggle_en 0.
  - In the first post-reset cycle: plot 1, vga_x 0, vga_y 0.
- Reset asserted mid-sweep: every enable is low in the next cycle, and the full INIT_DRAW sequence restarts. A partial CALC or COMMIT is not resumed.
- Edit latency: acceptance edge, 1 EDIT cycle, CELL_PX^2 plot cycles; ready returns after CELL_PX^2+1 busy cycles (17 at defaults).
- Generation latency: 2N + N*CELL_PX^2 busy cycles (64+64+1024 = 1152 at defaults).
- If edit_req and step arrive in the same IDLE cycle, the edit is accepted and the step is dropped.
- If step and a timed tick coincide, exactly one generation runs and tick_pending is cleared.

## Test plan
- Reset released: exactly 1024 consecutive plot cycles; first pixel (0,0), last pixel (31,31); colour follows cell_alive. ready rises on cycle 1025.
- From IDLE, edit_req with edit_x=2, edit_y=5: one toggle_en cycle with cell_x=2 and cell_y=5, then 16 plots covering x 8..11 and y 20..23. ready returns 17 cycles after acceptance.
- step pulse in IDLE: 64 calc_en cycles with addresses 0..63 in raster order, then 64 commit_en cycles. gen_count goes from 0 to 1 on commit cycle 64, followed by 1024 plots, one gen_done pulse, and ready.
- run=1 with TICK_CYCLES=2000: generations start at successive ticks. gen_count reaches 3 after 3 ticks. Dropping run stops new generations but lets the current one finish.
- step and edit_req asserted during CALC: both are ignored and the sweep count is unchanged. Simultaneous edit_req and step in IDLE: only EDIT occurs.
- resetn pulsed low at CALC index 30: the next cycle has calc_en=0, gen_count remains 0, and INIT_DRAW restarts from (0,0).
